// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle RISC-V ALU with valid/ready handshake on both sides
// Optional iterative multiply/divide is built only when ALU_MULDIV_EN is defined.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUCtl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             cout,
  output logic             div_by_zero,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;
`ifdef ALU_MULDIV_EN
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state;

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf;
  logic             sc_cout;
  logic             sc_ill;

  // only the low SHW bits of B select the shift distance
  assign shamt = B[SHW-1:0];

`ifdef ALU_MULDIV_EN
  logic             sc_dbz;
  logic             multi;
  logic             md_mul;
  logic             md_rem;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] md_acc;
  logic [WIDTH-1:0] md_x;
  logic [WIDTH-1:0] md_y;
  logic [WIDTH-1:0] acc_n;
  logic [WIDTH-1:0] x_n;
  logic [WIDTH-1:0] md_final;
  logic [WIDTH:0]   part;
  logic [WIDTH:0]   trial;
`else
  assign div_by_zero = 1'b0;
`endif

  // single-cycle result and flags straight from the live inputs, used on acceptance
  always_comb begin
    sc_res  = '0;
    sc_ovf  = 1'b0;
    sc_cout = 1'b0;
    sc_ill  = 1'b0;
    sum     = '0;
`ifdef ALU_MULDIV_EN
    sc_dbz  = 1'b0;
    multi   = 1'b0;
`endif
    case (ALUCtl)
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_XOR:  sc_res = A ^ B;
      OP_NOR:  sc_res = ~(A | B);
      OP_ADD: begin
        sum     = {1'b0, A} + {1'b0, B};
        sc_res  = sum[WIDTH-1:0];
        sc_cout = sum[WIDTH];
        sc_ovf  = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        // cout is the carry of A + ~B + 1, i.e. 1 means no borrow
        sum     = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        sc_res  = sum[WIDTH-1:0];
        sc_cout = sum[WIDTH];
        sc_ovf  = (A[WIDTH-1] != B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  sc_res = A << shamt;
      OP_SRL:  sc_res = A >> shamt;
      OP_SRA:  sc_res = $signed(A) >>> shamt;
`ifdef ALU_MULDIV_EN
      OP_MUL:  multi = 1'b1;
      OP_DIVU: begin
        // divide by zero finishes immediately with the RISC-V defined quotient
        if (B == '0) begin
          sc_res = '1;
          sc_dbz = 1'b1;
        end else begin
          multi = 1'b1;
        end
      end
      OP_REMU: begin
        if (B == '0) begin
          sc_res = A;
          sc_dbz = 1'b1;
        end else begin
          multi = 1'b1;
        end
      end
`endif
      default: sc_ill = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  // one iteration step: shift-add multiply, or one restoring-division quotient bit
  always_comb begin
    // md_acc holds the partial product (MUL) or the partial remainder (DIVU/REMU);
    // md_x holds the shifting multiplicand or the dividend turning into the quotient
    part  = {md_acc, md_x[WIDTH-1]};
    trial = part - {1'b0, md_y};
    acc_n = md_acc;
    x_n   = md_x;
    if (md_mul) begin
      acc_n = md_y[0] ? (md_acc + md_x) : md_acc;
      x_n   = md_x << 1;
    end else if (!trial[WIDTH]) begin
      acc_n = trial[WIDTH-1:0];
      x_n   = {md_x[WIDTH-2:0], 1'b1};
    end else begin
      acc_n = part[WIDTH-1:0];
      x_n   = {md_x[WIDTH-2:0], 1'b0};
    end
    md_final = (md_mul || md_rem) ? acc_n : x_n;
  end
`endif

  // control FSM with registered handshake, result and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      cout      <= 1'b0;
      illegal   <= 1'b0;
`ifdef ALU_MULDIV_EN
      div_by_zero <= 1'b0;
      md_mul      <= 1'b0;
      md_rem      <= 1'b0;
      md_acc      <= '0;
      md_x        <= '0;
      md_y        <= '0;
      cnt         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
`ifdef ALU_MULDIV_EN
            if (multi) begin
              // operands are copied so the requester may change them right away
              state       <= BUSY;
              result      <= '0;
              zero        <= 1'b0;
              overflow    <= 1'b0;
              cout        <= 1'b0;
              illegal     <= 1'b0;
              div_by_zero <= 1'b0;
              cnt         <= '0;
              md_mul      <= (ALUCtl == OP_MUL);
              md_rem      <= (ALUCtl == OP_REMU);
              md_acc      <= '0;
              md_x        <= A;
              md_y        <= B;
            end else
`endif
            begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= sc_res;
              zero      <= (sc_res == '0);
              overflow  <= sc_ovf;
              cout      <= sc_cout;
              illegal   <= sc_ill;
`ifdef ALU_MULDIV_EN
              div_by_zero <= sc_dbz;
`endif
            end
          end
        end
`ifdef ALU_MULDIV_EN
        BUSY: begin
          md_acc <= acc_n;
          md_x   <= x_n;
          if (md_mul) begin
            md_y <= md_y >> 1;
          end
          if (cnt == SHW'(WIDTH - 1)) begin
            // last iteration: publish the value the step just produced
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= md_final;
            zero      <= (md_final == '0);
          end else begin
            cnt <= cnt + SHW'(1);
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed self-checking bench for alu_mc against a behavioural model
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUCtl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        cout;
  logic        div_by_zero;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_res;
  logic        exp_zero, exp_ovf, exp_cout, exp_dbz, exp_ill;
  int          exp_lat;
  logic        chk_en = 1'b0;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUCtl(ALUCtl), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .overflow(overflow), .cout(cout),
    .div_by_zero(div_by_zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, required finish");
    $fatal(1);
  end

  // behavioural model: outputs from plain wide arithmetic
  function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ov, output logic co,
                                output logic dz, output logic il, output int lat);
    longint      sa, sb, s;
    logic [63:0] u;
    int          sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b[4:0]);
    r = 32'h0; ov = 1'b0; co = 1'b0; dz = 1'b0; il = 1'b0; lat = 1;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0011: r = a ^ b;
      4'b1100: r = ~(a | b);
      4'b0010: begin
        u = {32'h0, a} + {32'h0, b};
        r = u[31:0]; co = u[32];
        s = sa + sb; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        r = a - b; co = (a >= b);
        s = sa - sb; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1000: r = (a < b) ? 32'd1 : 32'd0;
      4'b0100: r = a << sh;
      4'b0101: r = a >> sh;
      4'b1101: begin s = sa >>> sh; r = s[31:0]; end
`ifdef ALU_MULDIV_EN
      4'b1001: begin u = {32'h0, a} * {32'h0, b}; r = u[31:0]; lat = 33; end
      4'b1010: if (b == 0) begin r = 32'hFFFFFFFF; dz = 1'b1; end else begin r = a / b; lat = 33; end
      4'b1011: if (b == 0) begin r = a; dz = 1'b1; end else begin r = a % b; lat = 33; end
`endif
      default: il = 1'b1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // compare process: every cycle the result is presented it must match the model
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      checks++;
      if (!chk_en || result !== exp_res || zero !== exp_zero || overflow !== exp_ovf ||
          cout !== exp_cout || div_by_zero !== exp_dbz || illegal !== exp_ill || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL done_outputs: got res=%h z=%b ov=%b co=%b dz=%b il=%b rdy=%b, expected res=%h z=%b ov=%b co=%b dz=%b il=%b rdy=0",
                 result, zero, overflow, cout, div_by_zero, illegal, in_ready,
                 exp_res, exp_zero, exp_ovf, exp_cout, exp_dbz, exp_ill);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // present one request, then wait (bounded) for out_valid and check the latency
  task automatic start_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int lat;
    model(c, a, b, exp_res, exp_ovf, exp_cout, exp_dbz, exp_ill, exp_lat);
    exp_zero = (exp_res == 32'h0);
    chk_en = 1'b1;
    chk("ready_before_accept", {31'h0, in_ready}, 32'h1);
    ALUCtl = c; A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = $urandom; B = $urandom; ALUCtl = 4'(c + 4'd1);
    lat = 1;
    while (!out_valid && lat < 100) begin
      chk("ready_low_busy", {31'h0, in_ready}, 32'h0);
      in_valid = lat[0];
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    if (!out_valid) begin
      chk_en = 1'b0;
      do_reset();
    end
  endtask

  // hold the result for some cycles, then consume it and expect IDLE next cycle
  task automatic release_op(input int hold);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid_ready", {30'h0, out_valid, in_ready}, 32'h2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk_en = 1'b0;
    chk("idle_after_consume", {30'h0, out_valid, in_ready}, 32'h1);
  endtask

  task automatic reset_check();
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid_ready", {30'h0, out_valid, in_ready}, 32'h1);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", {27'h0, zero, overflow, cout, div_by_zero, illegal}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; ALUCtl = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid_ready", {30'h0, out_valid, in_ready}, 32'h1);
    chk("reset_result", result, 32'h0);
    chk("reset_flags", {27'h0, zero, overflow, cout, div_by_zero, illegal}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // out_ready while nothing is valid changes nothing
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    chk("idle_out_ready", {30'h0, out_valid, in_ready}, 32'h1);

    start_op(4'b0010, 32'h7FFFFFFF, 32'h1);
    chk("add_ovf_res", result, 32'h80000000);
    chk("add_ovf_flags", {29'h0, overflow, cout, zero}, 32'h4);
    release_op(0);

    start_op(4'b0010, 32'hFFFFFFFF, 32'h1);
    chk("add_carry_res", result, 32'h0);
    chk("add_carry_flags", {29'h0, overflow, cout, zero}, 32'h3);
    release_op(0);

    start_op(4'b0110, 32'd5, 32'd5);
    chk("sub_eq", {30'h0, cout, zero}, 32'h3);
    release_op(0);

    start_op(4'b0110, 32'd3, 32'd5);
    chk("sub_borrow", result, 32'hFFFFFFFE);
    release_op(0);

    start_op(4'b0110, 32'h80000000, 32'h1);
    chk("sub_ovf", {31'h0, overflow}, 32'h1);
    release_op(0);

    start_op(4'b0111, 32'hFFFFFFFE, 32'h1);
    chk("slt", result, 32'h1);
    release_op(0);

    start_op(4'b1000, 32'hFFFFFFFE, 32'h1);
    chk("sltu", result, 32'h0);
    release_op(0);

    start_op(4'b1101, 32'h80000000, 32'h24);
    chk("sra", result, 32'hF8000000);
    release_op(0);

    start_op(4'b0101, 32'h80000000, 32'h24);
    chk("srl", result, 32'h08000000);
    release_op(0);

    start_op(4'b0100, 32'h1, 32'h3F);
    chk("sll", result, 32'h80000000);
    release_op(0);

    start_op(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00); chk("and", result, 32'hF000F000); release_op(0);
    start_op(4'b0001, 32'hF0F0F0F0, 32'hFF00FF00); chk("or",  result, 32'hFFF0FFF0); release_op(0);
    start_op(4'b0011, 32'hF0F0F0F0, 32'hFF00FF00); chk("xor", result, 32'h0FF00FF0); release_op(0);
    // backpressure: result must sit unchanged for 5 cycles
    start_op(4'b1100, 32'hF0F0F0F0, 32'hFF00FF00); chk("nor", result, 32'h000F000F); release_op(5);

    start_op(4'b1001, 32'h00012345, 32'h00000100);
`ifdef ALU_MULDIV_EN
    chk("mul", result, 32'h01234500);
`else
    chk("mul_illegal", {result[30:0], illegal}, 32'h1);
`endif
    release_op(0);

    start_op(4'b1010, 32'd100, 32'd7);
`ifdef ALU_MULDIV_EN
    chk("divu", result, 32'd14);
`endif
    release_op(0);
    start_op(4'b1011, 32'd100, 32'd7);
`ifdef ALU_MULDIV_EN
    chk("remu", result, 32'd2);
`endif
    release_op(0);
    start_op(4'b1010, 32'd9, 32'd0);
`ifdef ALU_MULDIV_EN
    chk("divu_zero", {result[30:0], div_by_zero}, 32'hFFFFFFFF);
`endif
    release_op(0);
    start_op(4'b1011, 32'd9, 32'd0);
`ifdef ALU_MULDIV_EN
    chk("remu_zero", result, 32'd9);
`endif
    release_op(0);
    start_op(4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF); release_op(1);
    start_op(4'b1010, 32'hFFFFFFFF, 32'h00000003); release_op(0);

    start_op(4'b1110, 32'h12345678, 32'h1);
    chk("illegal_1110", {result[30:0], illegal}, 32'h1);
    release_op(0);
    start_op(4'b1111, 32'h12345678, 32'h1);
    chk("illegal_1111", {result[30:0], illegal}, 32'h1);
    release_op(2);

    // reset mid-operation
`ifdef ALU_MULDIV_EN
    ALUCtl = 4'b1001; A = 32'h00012345; B = 32'h00000100; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("busy_before_reset", {30'h0, out_valid, in_ready}, 32'h0);
`else
    start_op(4'b0010, 32'd1, 32'd2);
`endif
    reset_check();

    // block is usable again after the reset
    start_op(4'b0010, 32'd40, 32'd2);
    chk("add_after_reset", result, 32'd42);
    release_op(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
